// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_t : sequencer states (IDLE, ACCESS, RESP)
//   arb_owner_t : which requester holds/held the memory (OWN_CPU, OWN_DBG)
//   ARB_CNT_W   : width of the wait-cycle counter (WAIT_CYCLES up to 15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_owner_t;

  localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the two requesters, the arbiter and
// the single-port memory.
//   cpu_* / dbg_* : requester ports (req, we, adr, wd in; rd, ready out)
//   mem_*         : memory port (we, adr, wd out; rd in, combinational)
//   owner         : current or last grant, 0 = CPU, 1 = debug
// Modports:
//   master : the arbiter, which masters the memory and answers requesters
//   slave  : the environment (requesters and memory)
// Handshake: req is a level held until the matching one-cycle ready pulse;
// the requester drops req in the cycle after ready, and a req still high in
// that cycle is a new request. rd is valid only while ready is high.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_wd;
  logic [DATA_W-1:0] cpu_rd;
  logic              cpu_ready;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_adr;
  logic [DATA_W-1:0] dbg_wd;
  logic [DATA_W-1:0] dbg_rd;
  logic              dbg_ready;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  logic              owner;

  modport master (
    input  cpu_req, cpu_we, cpu_adr, cpu_wd,
    output cpu_rd, cpu_ready,
    input  dbg_req, dbg_we, dbg_adr, dbg_wd,
    output dbg_rd, dbg_ready,
    output mem_we, mem_adr, mem_wd,
    input  mem_rd,
    output owner
  );

  modport slave (
    output cpu_req, cpu_we, cpu_adr, cpu_wd,
    input  cpu_rd, cpu_ready,
    output dbg_req, dbg_we, dbg_adr, dbg_wd,
    input  dbg_rd, dbg_ready,
    input  mem_we, mem_adr, mem_wd,
    output mem_rd,
    input  owner
  );

endinterface

// File: rtl/mem_arbiter_rr2.sv
// arb_rr2: combinational 2-way round-robin picker.
//   req_cpu, req_dbg : requests
//   last             : requester granted last time
//   gnt_valid        : at least one request present
//   winner           : granted requester; on a tie, the one not granted last
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_dbg,
  input  arb_owner_t last,
  output logic       gnt_valid,
  output arb_owner_t winner
);

  always_comb begin
    gnt_valid = req_cpu | req_dbg;
    winner    = OWN_CPU;
    if (req_cpu && req_dbg) begin
      winner = (last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (req_dbg) begin
      winner = OWN_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port unified memory of the multicycle MIPS
// core between the CPU and a debug/loader port. Each granted access runs
// WAIT_CYCLES memory cycles, then the winner gets a one-cycle ready pulse.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : mem_arbiter_if.master (requester and memory signals)
//   state        : current sequencer state, for observation
// Build option: MEM_ARB_DBG_EN enables the debug port. Without it dbg_req
// is ignored, dbg_ready/dbg_rd/owner are constant 0 and no last-grant
// register exists; CPU timing is the same in both builds.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.master bus,
  output arb_state_t    state
);

  localparam logic [ARB_CNT_W-1:0] CNT_INIT = ARB_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ARB_CNT_W-1:0] CNT_ONE  = ARB_CNT_W'(1);

  arb_state_t           state_q;
  arb_owner_t           owner_q;
  arb_owner_t           last_q;
  arb_owner_t           winner;
  logic                 gnt_valid;
  logic                 dbg_req_eff;
  logic [ARB_CNT_W-1:0] cnt_q;
  logic                 we_q;
  logic                 mem_we_q;
  logic                 ready_q;
  logic [ADDR_W-1:0]    adr_q;
  logic [DATA_W-1:0]    wd_q;
  logic [DATA_W-1:0]    rd_q;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_adr;
  logic [DATA_W-1:0]    sel_wd;
  logic                 cpu_ready_w;

`ifdef MEM_ARB_DBG_EN
  assign dbg_req_eff = bus.dbg_req;
`else
  logic unused_dbg_req;
  assign unused_dbg_req = bus.dbg_req;
  assign dbg_req_eff    = 1'b0;
  // Without a debug port the CPU always wins, so the history is a constant.
  assign last_q         = OWN_DBG;
`endif

  arb_rr2 u_rr2 (
    .req_cpu   (bus.cpu_req),
    .req_dbg   (dbg_req_eff),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .winner    (winner)
  );

  always_comb begin
    sel_we  = bus.cpu_we;
    sel_adr = bus.cpu_adr;
    sel_wd  = bus.cpu_wd;
    if (winner == OWN_DBG) begin
      sel_we  = bus.dbg_we;
      sel_adr = bus.dbg_adr;
      sel_wd  = bus.dbg_wd;
    end
  end

  // mem_we and ready are registered one cycle ahead: mem_we is raised on the
  // edge that enters the final ACCESS cycle (counter reaching 0), ready on
  // the edge that leaves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      owner_q  <= OWN_CPU;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
      mem_we_q <= 1'b0;
      ready_q  <= 1'b0;
`ifdef MEM_ARB_DBG_EN
      last_q   <= OWN_DBG;
`endif
    end else begin
      mem_we_q <= 1'b0;
      ready_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            state_q  <= ACCESS;
            owner_q  <= winner;
            we_q     <= sel_we;
            adr_q    <= sel_adr;
            wd_q     <= sel_wd;
            cnt_q    <= CNT_INIT;
            mem_we_q <= sel_we && (CNT_INIT == '0);
`ifdef MEM_ARB_DBG_EN
            last_q   <= winner;
`endif
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            rd_q    <= bus.mem_rd;
            ready_q <= 1'b1;
          end else begin
            cnt_q    <= cnt_q - CNT_ONE;
            mem_we_q <= we_q && (cnt_q == CNT_ONE);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign bus.mem_we  = mem_we_q;
  assign bus.mem_adr = adr_q;
  assign bus.mem_wd  = wd_q;

  assign cpu_ready_w   = ready_q && (owner_q == OWN_CPU);
  assign bus.cpu_ready = cpu_ready_w;
  assign bus.cpu_rd    = cpu_ready_w ? rd_q : '0;

`ifdef MEM_ARB_DBG_EN
  logic dbg_ready_w;
  assign dbg_ready_w   = ready_q && (owner_q == OWN_DBG);
  assign bus.dbg_ready = dbg_ready_w;
  assign bus.dbg_rd    = dbg_ready_w ? rd_q : '0;
  assign bus.owner     = owner_q;
`else
  assign bus.dbg_ready = 1'b0;
  assign bus.dbg_rd    = '0;
  assign bus.owner     = 1'b0;
`endif

endmodule
